// File: rtl/trigger_sequencer.sv
// Trigger sequencer: coincidence window, readout handshake,
// latch-bank clear pulse and dead time, with event statistics.
module trigger_sequencer #(
   parameter int WINDOW_CYCLES  = 16,
   parameter int CLEAR_CYCLES   = 4,
   parameter int DEAD_CYCLES    = 64,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [23:0] hits,
   input  logic        readout_ack,
   output logic        trigger,
   output logic        latch_clr,
   output logic        busy,
   output logic [15:0] event_count,
   output logic [15:0] drop_count,
   output logic [15:0] timeout_count,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WINDOW = 3'd1,
      ST_WAIT   = 3'd2,
      ST_CLEAR  = 3'd3,
      ST_DEAD   = 3'd4
   } state_t;

   // Terminal timer values; each phase runs timer 0..N-1.
   localparam logic [23:0] LP_WIN_LAST  = 24'(WINDOW_CYCLES - 1);
   localparam logic [23:0] LP_CLR_LAST  = 24'(CLEAR_CYCLES - 1);
   localparam logic [23:0] LP_DEAD_LAST = 24'(DEAD_CYCLES - 1);
   localparam logic [23:0] LP_TO_LAST   = 24'(TIMEOUT_CYCLES - 1);
   localparam bit          LP_NO_DEAD   = (DEAD_CYCLES == 0);

   state_t      r_state;
   logic [23:0] r_timer;
   logic        r_trigger;
   logic        r_latch_clr;
   logic        r_busy;
   logic [15:0] r_event_count;
   logic [15:0] r_drop_count;
   logic [15:0] r_timeout_count;

   logic [11:0] w_pair;
   logic        w_coin;
   logic        w_any_hit;

   // Per-layer-pair OR; coincidence needs every pair lit.
   always_comb begin
      w_pair = '0;
      for (int p = 0; p < 12; p++) begin
         w_pair[p] = hits[2*p] | hits[2*p+1];
      end
   end

   assign w_coin    = &w_pair;
   assign w_any_hit = |hits;

   // Sequencer state, phase timer, registered outputs and counters.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_timer         <= '0;
         r_trigger       <= 1'b0;
         r_latch_clr     <= 1'b0;
         r_busy          <= 1'b0;
         r_event_count   <= '0;
         r_drop_count    <= '0;
         r_timeout_count <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (enable && w_any_hit) begin
                  r_state <= ST_WINDOW;
                  r_timer <= '0;
                  r_busy  <= 1'b1;
               end
            end
            ST_WINDOW: begin
               if (w_coin) begin
                  r_state   <= ST_WAIT;
                  r_timer   <= '0;
                  r_trigger <= 1'b1;
                  if (r_event_count != 16'hFFFF)
                     r_event_count <= r_event_count + 16'd1;
               end else if (r_timer == LP_WIN_LAST) begin
                  r_state     <= ST_CLEAR;
                  r_timer     <= '0;
                  r_latch_clr <= 1'b1;
                  if (r_drop_count != 16'hFFFF)
                     r_drop_count <= r_drop_count + 16'd1;
               end else begin
                  r_timer <= r_timer + 24'd1;
               end
            end
            ST_WAIT: begin
               if (readout_ack) begin
                  r_state     <= ST_CLEAR;
                  r_timer     <= '0;
                  r_trigger   <= 1'b0;
                  r_latch_clr <= 1'b1;
               end else if (r_timer == LP_TO_LAST) begin
                  r_state     <= ST_CLEAR;
                  r_timer     <= '0;
                  r_trigger   <= 1'b0;
                  r_latch_clr <= 1'b1;
                  if (r_timeout_count != 16'hFFFF)
                     r_timeout_count <= r_timeout_count + 16'd1;
               end else begin
                  r_timer <= r_timer + 24'd1;
               end
            end
            ST_CLEAR: begin
               if (r_timer == LP_CLR_LAST) begin
                  r_timer     <= '0;
                  r_latch_clr <= 1'b0;
                  if (LP_NO_DEAD) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= ST_DEAD;
                  end
               end else begin
                  r_timer <= r_timer + 24'd1;
               end
            end
            ST_DEAD: begin
               if (r_timer == LP_DEAD_LAST) begin
                  r_state <= ST_IDLE;
                  r_timer <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_timer <= r_timer + 24'd1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_timer     <= '0;
               r_trigger   <= 1'b0;
               r_latch_clr <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign trigger       = r_trigger;
   assign latch_clr     = r_latch_clr;
   assign busy          = r_busy;
   assign event_count   = r_event_count;
   assign drop_count    = r_drop_count;
   assign timeout_count = r_timeout_count;
   assign state_dbg     = r_state;

endmodule

// File: doc/trigger_sequencer.md
TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

Interface
REQ-001 SHALL have parameter WINDOW_CYCLES, default 16: coincidence window length in sys_clk cycles, range 1..255.
REQ-002 SHALL have parameter CLEAR_CYCLES, default 4: latch_clr pulse width in cycles, range 1..15.
REQ-003 SHALL have parameter DEAD_CYCLES, default 64: dead time after clear, range 0..65535.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1048576: readout timeout, range 1..2^24-1.
REQ-005 SHALL have port sys_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port enable, input, 1: high permits new events to start.
REQ-008 SHALL have port hits, input, 24: latched hit bits from the latch bank, 12 layer pairs {[1:0],[3:2],...,[23:22]}.
REQ-009 SHALL have port readout_ack, input, 1: single-cycle pulse from host meaning "readout complete".
REQ-010 SHALL have port trigger, output, 1: event ready for readout.
REQ-011 SHALL have port latch_clr, output, 1: active-high clear to the latch bank.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port event_count, output, 16: accepted events.
REQ-014 SHALL have port drop_count, output, 16: windows expired without coincidence.
REQ-015 SHALL have port timeout_count, output, 16: readouts aborted by timeout.
REQ-016 SHALL have port state_dbg, output, 3: current state encoding.

Function
REQ-017 SHALL implement states IDLE=0, WINDOW=1, WAIT_READ=2, CLEAR=3, DEAD=4; codes 5-7 SHALL return to IDLE next cycle.
REQ-018 SHALL define coincidence as: each of the 12 hits pairs has at least one bit set, evaluated combinationally on hits.
REQ-019 SHALL move IDLE -> WINDOW when enable=1 and hits!=0; window counter loads 0 on entry.
REQ-020 SHALL, in WINDOW, check coincidence every cycle, including the first, and on true move to WAIT_READ.
REQ-021 SHALL, in WINDOW, move to CLEAR and increment drop_count when WINDOW_CYCLES cycles have elapsed without coincidence.
REQ-022 SHALL give coincidence priority over window expiry in the same cycle.
REQ-023 SHALL increment event_count on the WINDOW -> WAIT_READ transition.
REQ-024 SHALL hold trigger high exactly while in WAIT_READ, registered, with no combinational path from hits.
REQ-025 SHALL have latency from hits satisfying coincidence while in IDLE (cycle N): WINDOW at N+1, trigger=1 at N+2.
REQ-026 SHALL, in WAIT_READ, move to CLEAR on readout_ack=1.
REQ-027 SHALL, in WAIT_READ, move to CLEAR and increment timeout_count after TIMEOUT_CYCLES cycles without readout_ack.
REQ-028 SHALL give readout_ack priority over timeout in the same cycle; timeout_count unchanged.
REQ-029 SHALL ignore readout_ack in every state except WAIT_READ.
REQ-030 SHALL hold latch_clr high for exactly CLEAR_CYCLES cycles in CLEAR, then enter DEAD.
REQ-031 SHALL stay in DEAD for DEAD_CYCLES cycles, then enter IDLE; DEAD_CYCLES=0 means CLEAR -> IDLE directly.
REQ-032 SHALL ignore hits in WAIT_READ, CLEAR and DEAD.
REQ-033 SHALL let enable gate only the IDLE exit; deasserting enable SHALL NOT abort a sequence in progress.
REQ-034 SHALL saturate all three counters at 0xFFFF, with no wrap.
REQ-035 SHALL, when hits are still nonzero in IDLE after DEAD, treat them as a new event (IDLE -> WINDOW).

Reset
REQ-036 SHALL, while rst=1, immediately force state IDLE, trigger=0, latch_clr=0, busy=0, all counters 0 and all timers 0, independent of sys_clk.
REQ-037 SHALL make reset asserted mid-sequence, including mid-CLEAR, drop latch_clr at once; no clear completes after release.
REQ-038 SHALL resume evaluation on the first sys_clk rising edge after rst falls.

Verification (WINDOW_CYCLES=4, CLEAR_CYCLES=2, DEAD_CYCLES=3, TIMEOUT_CYCLES=10)
REQ-039 SHALL cover: hits=0xFFFFFF at cycle N from IDLE -> trigger=1 at N+2; ack at N+5 -> latch_clr=1 at N+6 and N+7; IDLE at N+11; event_count=1.
REQ-040 SHALL cover: hits=0x000003 held -> WINDOW for 4 cycles, then CLEAR; drop_count=1, trigger never high.
REQ-041 SHALL cover: coincidence, no ack -> trigger high 10 cycles, then CLEAR; timeout_count=1, event_count=1.
REQ-042 SHALL cover: ack on the same cycle as timeout -> CLEAR, timeout_count=0.
REQ-043 SHALL cover: rst=1 pulse during CLEAR -> latch_clr=0 within the same cycle; counters=0; state_dbg=0.
REQ-044 SHALL cover: enable=0 with hits=0xFFFFFF -> stays IDLE, busy=0; enable=0 asserted in WAIT_READ -> ack still completes CLEAR and DEAD.
